conv_stream_driver: RTL and testbench

- Producer-side sequencer for the convolution controller.
- Generates the controller's input strobes (coeff_load_en, sample_load_en, new_row) and drives the coefficient and sample data buses.
- Pops one frame of WIDTH x HEIGHT pixels from an upstream pixel FIFO, honouring the controller's modwait back-pressure.
- Sits between the pixel buffer and the convolution datapath/controller pair.

---
 rtl/conv_stream_driver_if.sv | 24 ++
 rtl/conv_stream_driver.sv | 151 +++++++++++++++
 tb/tb_conv_stream_driver.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_driver_if.sv
// rtl/conv_stream_driver_if.sv - pixel FIFO and convolution controller signal bundle
interface conv_stream_driver_if #(
  parameter int DATA_W = 8
);
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              modwait;
  logic              coeff_load_en;
  logic              sample_load_en;
  logic              new_row;
  logic [DATA_W-1:0] coeff_data;
  logic [DATA_W-1:0] sample_data;

  modport master (
    input  pix_valid, pix_data, modwait,
    output pix_ready, coeff_load_en, sample_load_en, new_row, coeff_data, sample_data
  );

  modport slave (
    output pix_valid, pix_data, modwait,
    input  pix_ready, coeff_load_en, sample_load_en, new_row, coeff_data, sample_data
  );
endinterface

// File: rtl/conv_stream_driver.sv
// rtl/conv_stream_driver.sv - producer-side strobe sequencer feeding the convolution controller
module conv_stream_driver #(
  parameter int DATA_W = 8,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    coeff0,
  input  logic [DATA_W-1:0]    coeff1,
  input  logic [DATA_W-1:0]    coeff2,
  conv_stream_driver_if.master sif,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [3:0] {
    IDLE, CF_REQ, CF_DATA, SMP_WAIT, SMP_ISSUE, SMP_HOLD, END_WAIT, END_ISSUE, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              last_pix;
  logic [DATA_W-1:0] cf0, cf1, cf2;
  logic [DATA_W-1:0] sample_q;

  logic              pop;
  logic              cle;
  logic              sle;
  logic              nr;
  logic [DATA_W-1:0] cdata;

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and all strobes, decoded straight from state so reset clears them at once.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cle       = 1'b0;
    sle       = 1'b0;
    nr        = 1'b0;
    cdata     = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CF_REQ;
      end
      CF_REQ: begin
        cle       = 1'b1;
        state_nxt = CF_DATA;
      end
      CF_DATA: begin
        case (idx)
          2'd0:    cdata = cf0;
          2'd1:    cdata = cf1;
          default: cdata = cf2;
        endcase
        if (idx == 2'd2) state_nxt = SMP_WAIT;
      end
      SMP_WAIT: begin
        if (!sif.modwait && sif.pix_valid) begin
          pop       = 1'b1;
          state_nxt = SMP_ISSUE;
        end
      end
      SMP_ISSUE: begin
        // First pixel of every row after the first is announced as a row start only.
        if (row != '0 && col == '0) nr  = 1'b1;
        else                        sle = 1'b1;
        state_nxt = SMP_HOLD;
      end
      SMP_HOLD: begin
        state_nxt = last_pix ? END_WAIT : SMP_WAIT;
      end
      END_WAIT: begin
        if (!sif.modwait) state_nxt = END_ISSUE;
      end
      END_ISSUE: begin
        sle       = 1'b1;
        nr        = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coefficient latches, sample register and row/column bookkeeping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx      <= '0;
      col      <= '0;
      row      <= '0;
      last_pix <= 1'b0;
      cf0      <= '0;
      cf1      <= '0;
      cf2      <= '0;
      sample_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cf0      <= coeff0;
            cf1      <= coeff1;
            cf2      <= coeff2;
            idx      <= '0;
            col      <= '0;
            row      <= '0;
            last_pix <= 1'b0;
          end
        end
        CF_DATA: idx <= idx + 2'd1;
        SMP_WAIT: begin
          if (pop) sample_q <= sif.pix_data;
        end
        SMP_ISSUE: begin
          // Flag kept separately so the row counter may wrap without losing end-of-frame.
          last_pix <= (row == ROW_LAST) && (col == COL_LAST);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sif.pix_ready      = pop;
  assign sif.coeff_load_en  = cle;
  assign sif.sample_load_en = sle;
  assign sif.new_row        = nr;
  assign sif.coeff_data     = cdata;
  assign sif.sample_data    = sample_q;
  assign busy               = (state != IDLE);
  assign frame_done         = (state == DONE);
endmodule

// File: tb/tb_conv_stream_driver.sv
// tb/tb_conv_stream_driver.sv - directed self-checking bench for conv_stream_driver
module tb_conv_stream_driver;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] c0 = '0, c1 = '0, c2 = '0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       modwait = 1'b0;
  logic       busy_a, busy_b, fd_a, fd_b;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  conv_stream_driver_if #(.DATA_W(8)) ia ();
  conv_stream_driver_if #(.DATA_W(8)) ib ();

  assign ia.pix_valid = pix_valid;
  assign ia.pix_data  = pix_data;
  assign ia.modwait   = modwait;
  assign ib.pix_valid = pix_valid;
  assign ib.pix_data  = pix_data;
  assign ib.modwait   = modwait;

  conv_stream_driver #(.DATA_W(8), .WIDTH(4), .HEIGHT(2)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start_a), .coeff0(c0), .coeff1(c1), .coeff2(c2),
    .sif(ia), .busy(busy_a), .frame_done(fd_a)
  );

  conv_stream_driver #(.DATA_W(8), .WIDTH(3), .HEIGHT(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .coeff0(c0), .coeff1(c1), .coeff2(c2),
    .sif(ib), .busy(busy_b), .frame_done(fd_b)
  );

  wire       o_sle  = sel ? ib.sample_load_en : ia.sample_load_en;
  wire       o_nr   = sel ? ib.new_row        : ia.new_row;
  wire       o_cle  = sel ? ib.coeff_load_en  : ia.coeff_load_en;
  wire       o_pr   = sel ? ib.pix_ready      : ia.pix_ready;
  wire       o_busy = sel ? busy_b            : busy_a;
  wire       o_fd   = sel ? fd_b              : fd_a;
  wire [7:0] o_cd   = sel ? ib.coeff_data     : ia.coeff_data;
  wire [7:0] o_sd   = sel ? ib.sample_data    : ia.sample_data;

  int total = 0;
  int bad = 0;

  int         st_t[$];
  logic       st_sle[$];
  logic       st_nr[$];
  logic [7:0] st_sd[$];
  int         exp_t[$];
  logic [7:0] cd_log[256];
  int cle_cnt, cle_first, pops, adj, end_t, done_t, busy_gap, pidx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode 0 plain, 1 pix_valid gap, 2 modwait after each strobe, 3 start retrigger mid-frame
  task automatic run_frame(input logic s, input int mode, input logic [7:0] a0, a1, a2);
    int   ls;
    logic prev;
    logic popped;
    logic seen_done;
    sel = s;
    st_t.delete(); st_sle.delete(); st_nr.delete(); st_sd.delete();
    for (int i = 0; i < 256; i++) cd_log[i] = '0;
    cle_cnt = 0; cle_first = -1; pops = 0; adj = 0; end_t = -1; done_t = -1; busy_gap = 0;
    pidx = 0; ls = -100; prev = 1'b0; seen_done = 1'b0;
    pix_data = 8'h10;
    for (int t = 0; t < 300 && !seen_done; t++) begin
      if (s == 1'b0) start_a = (t == 0) || (mode == 3 && t == 15);
      else           start_b = (t == 0);
      if (mode == 3 && t == 15) {c0, c1, c2} = {8'd9, 8'd9, 8'd9};
      else                      {c0, c1, c2} = {a0, a1, a2};
      pix_valid = !(mode == 1 && t >= 12 && t < 22);
      modwait   = (mode == 2) && (t > ls) && (t <= ls + 5);
      @(negedge clk);
      if (t < 256) cd_log[t] = o_cd;
      if (o_cle) begin
        cle_cnt++;
        if (cle_first < 0) cle_first = t;
      end
      popped = o_pr;
      if (o_pr) pops++;
      if (o_sle || o_nr) begin
        st_t.push_back(t); st_sle.push_back(o_sle); st_nr.push_back(o_nr); st_sd.push_back(o_sd);
        if (prev) adj++;
        ls = t;
        if (o_sle && o_nr) end_t = t;
      end
      prev = o_sle || o_nr;
      if (t >= 1 && !o_busy) busy_gap++;
      if (o_fd) begin
        done_t = t;
        seen_done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (popped) pidx++;
      pix_data = 8'h10 + 8'(pidx);
    end
    start_a = 1'b0; start_b = 1'b0; pix_valid = 1'b0; modwait = 1'b0;
    chk("frame_done_seen", 32'(seen_done), 32'd1);
  endtask

  task automatic check_frame(input string nm, input int nr_k, input int endt, input int npix,
                             input logic [7:0] k0, k1, k2);
    int nz;
    nz = 0;
    chk({nm, "_cle_cycle"}, cle_first, 1);
    chk({nm, "_cle_count"}, cle_cnt, 1);
    chk({nm, "_coeff0"}, 32'(cd_log[2]), 32'(k0));
    chk({nm, "_coeff1"}, 32'(cd_log[3]), 32'(k1));
    chk({nm, "_coeff2"}, 32'(cd_log[4]), 32'(k2));
    for (int t = 0; t < 256 && t <= done_t; t++)
      if ((t < 2 || t > 4) && cd_log[t] != 8'h00) nz++;
    chk({nm, "_coeff_idle_zero"}, nz, 0);
    chk({nm, "_strobe_count"}, st_t.size(), npix + 1);
    for (int k = 0; k < npix && k < st_t.size() && k < exp_t.size(); k++) begin
      chk($sformatf("%s_strobe%0d_cycle", nm, k), st_t[k], exp_t[k]);
      chk($sformatf("%s_strobe%0d_sle", nm, k), 32'(st_sle[k]), 32'(k != nr_k));
      chk($sformatf("%s_strobe%0d_nr", nm, k), 32'(st_nr[k]), 32'(k == nr_k));
      chk($sformatf("%s_strobe%0d_data", nm, k), 32'(st_sd[k]), 32'h10 + k);
    end
    chk({nm, "_end_marker"}, end_t, endt);
    chk({nm, "_done_cycle"}, done_t, endt + 1);
    chk({nm, "_pops"}, pops, npix);
    chk({nm, "_adjacent"}, adj, 0);
    chk({nm, "_busy_gap"}, busy_gap, 0);
  endtask

  initial begin
    int nz;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_sample", 32'(ia.sample_data), 32'd0);
    chk("rst_strobes", 32'({ia.coeff_load_en, ia.sample_load_en, ia.new_row, ia.pix_ready, fd_a}), 32'd0);
    n_rst = 1'b1;

    // idle without start
    nz = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a || ia.sample_load_en || ia.new_row || ia.coeff_load_en || ia.pix_ready || fd_a ||
          (ia.coeff_data != 8'h00) || (ia.sample_data != 8'h00)) nz++;
    end
    @(posedge clk);
    #1;
    chk("idle_quiet", nz, 0);

    // plain frame, 4x2, coeffs 3/5/7
    run_frame(1'b0, 0, 8'd3, 8'd5, 8'd7);
    exp_t.delete();
    for (int k = 0; k < 8; k++) exp_t.push_back(6 + 3 * k);
    check_frame("plain", 4, 30, 8, 8'd3, 8'd5, 8'd7);

    // FIFO empty for 10 cycles after the 3rd pixel
    run_frame(1'b0, 1, 8'd3, 8'd5, 8'd7);
    exp_t = '{6, 9, 12, 23, 26, 29, 32, 35};
    check_frame("gap", 4, 38, 8, 8'd3, 8'd5, 8'd7);

    // modwait high for 5 cycles after every strobe
    run_frame(1'b0, 2, 8'd3, 8'd5, 8'd7);
    exp_t.delete();
    for (int k = 0; k < 8; k++) exp_t.push_back(6 + 7 * k);
    check_frame("modwait", 4, 62, 8, 8'd3, 8'd5, 8'd7);

    // start with other coeffs during the sample phase is ignored
    run_frame(1'b0, 3, 8'd3, 8'd5, 8'd7);
    exp_t.delete();
    for (int k = 0; k < 8; k++) exp_t.push_back(6 + 3 * k);
    check_frame("restart", 4, 30, 8, 8'd3, 8'd5, 8'd7);
    run_frame(1'b0, 0, 8'd2, 8'd4, 8'd6);
    check_frame("newcoef", 4, 30, 8, 8'd2, 8'd4, 8'd6);

    // single row, 3 pixels
    run_frame(1'b1, 0, 8'h0a, 8'h0b, 8'h0c);
    exp_t = '{6, 9, 12};
    check_frame("row1", -1, 15, 3, 8'h0a, 8'h0b, 8'h0c);

    // asynchronous reset in the middle of a frame
    sel = 1'b0;
    {c0, c1, c2} = {8'd1, 8'd2, 8'd3};
    pix_valid = 1'b1;
    pix_data = 8'h5a;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy_a), 32'd1);
    chk("mid_sample", 32'(ia.sample_data), 32'h5a);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_sample", 32'(ia.sample_data), 32'd0);
    chk("arst_strobes", 32'({ia.coeff_load_en, ia.sample_load_en, ia.new_row, ia.pix_ready, fd_a}), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_idle", 32'(busy_a), 32'd0);
    run_frame(1'b0, 0, 8'd3, 8'd5, 8'd7);
    exp_t.delete();
    for (int k = 0; k < 8; k++) exp_t.push_back(6 + 3 * k);
    check_frame("post_rst", 4, 30, 8, 8'd3, 8'd5, 8'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
